// File: rtl/piccolo_iter_core.sv
// Iterative Piccolo-80/128 encryption core.
// UNROLL rounds per clock, valid/ready on both sides.
module piccolo_iter_core #(
  parameter int KEY_BITS = 128,
  parameter int UNROLL   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [63:0]         plaintext,
  input  logic [KEY_BITS-1:0] key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [63:0]         ciphertext,
  output logic                busy
);

  localparam int NR = (KEY_BITS == 80) ? 25 : 31;
  localparam int RW = 7;

  if (KEY_BITS != 80 && KEY_BITS != 128) begin : g_bad_key
    $error("piccolo_iter_core: KEY_BITS must be 80 or 128");
  end
  if (UNROLL < 1 || UNROLL > NR) begin : g_bad_unroll
    $error("piccolo_iter_core: UNROLL out of range");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t              state;
  logic [KEY_BITS-1:0] kreg;
  logic [63:0]         x;
  logic [RW-1:0]       r;
  logic [63:0]         nx;

  function automatic logic [3:0] sb(input logic [3:0] a);
    unique case (a)
      4'h0: sb = 4'he;
      4'h1: sb = 4'h4;
      4'h2: sb = 4'hb;
      4'h3: sb = 4'h2;
      4'h4: sb = 4'h3;
      4'h5: sb = 4'h8;
      4'h6: sb = 4'h0;
      4'h7: sb = 4'h9;
      4'h8: sb = 4'h1;
      4'h9: sb = 4'ha;
      4'ha: sb = 4'h7;
      4'hb: sb = 4'hf;
      4'hc: sb = 4'h6;
      4'hd: sb = 4'hc;
      4'he: sb = 4'h5;
      default: sb = 4'hd;
    endcase
  endfunction

  // GF(2^4) doubling, x^4 = x + 1
  function automatic logic [3:0] m2(input logic [3:0] a);
    m2 = {a[2:0], 1'b0} ^ {2'b00, a[3], a[3]};
  endfunction

  function automatic logic [15:0] ff(input logic [15:0] a);
    logic [3:0] s0, s1, s2, s3;
    logic [3:0] y0, y1, y2, y3;
    s0 = sb(a[15:12]);
    s1 = sb(a[11:8]);
    s2 = sb(a[7:4]);
    s3 = sb(a[3:0]);
    y0 = m2(s0) ^ m2(s1) ^ s1 ^ s2 ^ s3;
    y1 = s0 ^ m2(s1) ^ m2(s2) ^ s2 ^ s3;
    y2 = s0 ^ s1 ^ m2(s2) ^ m2(s3) ^ s3;
    y3 = m2(s0) ^ s0 ^ s1 ^ s2 ^ m2(s3);
    ff = {sb(y0), sb(y1), sb(y2), sb(y3)};
  endfunction

  function automatic logic [63:0] rp(input logic [63:0] s);
    rp = {s[47:40], s[7:0], s[31:24], s[55:48],
          s[15:8], s[39:32], s[63:56], s[23:16]};
  endfunction

  function automatic logic [15:0] wd(
    input logic [KEY_BITS-1:0] k,
    input int                  j
  );
    wd = 16'(k >> (KEY_BITS - 16 - 16 * j));
  endfunction

  // 128-bit schedule: word index after the
  // (n+2)/8 cumulative key-word permutations
  function automatic int kidx(input int n);
    int idx;
    int m;
    idx = (n + 2) % 8;
    m   = (n + 2) / 8;
    for (int t = 0; t < 8; t++) begin
      if (t < m) begin
        case (idx)
          0: idx = 2;
          1: idx = 1;
          2: idx = 6;
          3: idx = 7;
          4: idx = 0;
          5: idx = 3;
          6: idx = 4;
          default: idx = 5;
        endcase
      end
    end
    kidx = idx;
  endfunction

  function automatic logic [31:0] con(input int i);
    logic [4:0]  c;
    logic [31:0] base;
    c    = 5'(i + 1);
    base = (KEY_BITS == 80) ? 32'h0f1e2d3c
                            : 32'h6547a98b;
    con  = {c, 5'd0, c, 2'd0, c, 5'd0, c} ^ base;
  endfunction

  function automatic logic [31:0] rkp(
    input logic [KEY_BITS-1:0] k,
    input int                  i
  );
    logic [31:0] kk;
    if (KEY_BITS == 80) begin
      case (i % 5)
        0, 2:    kk = {wd(k, 2), wd(k, 3)};
        1, 4:    kk = {wd(k, 0), wd(k, 1)};
        default: kk = {wd(k, 4), wd(k, 4)};
      endcase
    end else begin
      kk = {wd(k, kidx(2 * i)),
            wd(k, kidx(2 * i + 1))};
    end
    rkp = con(i) ^ kk;
  endfunction

  function automatic logic [63:0] rnd(
    input logic [63:0] s,
    input logic [31:0] rk,
    input logic        last
  );
    logic [63:0] t;
    t          = s;
    t[47:32]   = s[47:32] ^ ff(s[63:48]) ^ rk[31:16];
    t[15:0]    = s[15:0] ^ ff(s[31:16]) ^ rk[15:0];
    rnd        = last ? t : rp(t);
  endfunction

  function automatic logic [63:0] wi(
    input logic [63:0]         p,
    input logic [KEY_BITS-1:0] k
  );
    logic [15:0] w0, w1;
    w0 = wd(k, 0);
    w1 = wd(k, 1);
    wi = {p[63:48] ^ {w0[15:8], w1[7:0]},
          p[47:32],
          p[31:16] ^ {w1[15:8], w0[7:0]},
          p[15:0]};
  endfunction

  function automatic logic [63:0] wo(
    input logic [63:0]         s,
    input logic [KEY_BITS-1:0] k
  );
    logic [15:0] w4, wa;
    w4 = wd(k, 4);
    wa = wd(k, (KEY_BITS == 80) ? 3 : 7);
    wo = {s[63:48] ^ {w4[15:8], wa[7:0]},
          s[47:32],
          s[31:16] ^ {wa[15:8], w4[7:0]},
          s[15:0]};
  endfunction

  // Stages past round NR-1 pass the state through
  for (genvar g = 0; g < UNROLL; g++) begin : g_st
    logic [RW-1:0] ri;
    logic [63:0]   si;
    logic [63:0]   so;
    assign ri = r + RW'(g);
    if (g == 0) begin : g_in
      assign si = x;
    end else begin : g_lnk
      assign si = g_st[g-1].so;
    end
    assign so = (ri < RW'(NR))
              ? rnd(si, rkp(kreg, int'(ri)),
                    ri == RW'(NR - 1))
              : si;
  end

  assign nx = g_st[UNROLL-1].so;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      ciphertext <= '0;
      kreg       <= '0;
      x          <= '0;
      r          <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            kreg     <= key;
            x        <= wi(plaintext, key);
            r        <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end else begin
            in_ready <= 1'b1;
          end
        end
        RUN: begin
          if (r >= RW'(NR)) begin
            ciphertext <= wo(x, kreg);
            out_valid  <= 1'b1;
            busy       <= 1'b0;
            state      <= DONE;
          end else begin
            x <= nx;
            r <= r + RW'(UNROLL);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piccolo_iter_core.sv
// Scoreboard bench for piccolo_iter_core.
// Four configurations run side by side.
module tb_piccolo_iter_core;

  localparam int KBA  [4] = '{80, 128, 128, 128};
  localparam int UNA  [4] = '{1, 4, 3, 31};
  localparam int LATA [4] = '{26, 9, 12, 2};

  localparam logic [3:0] SB [16] = '{
    4'he, 4'h4, 4'hb, 4'h2, 4'h3, 4'h8, 4'h0, 4'h9,
    4'h1, 4'ha, 4'h7, 4'hf, 4'h6, 4'hc, 4'h5, 4'hd};
  localparam int MM  [16] = '{2, 3, 1, 1, 1, 2, 3, 1,
                               1, 1, 2, 3, 3, 1, 1, 2};
  localparam int RPM [8]  = '{2, 7, 4, 1, 6, 3, 0, 5};

  localparam logic [127:0] K80  = 128'h00112233445566778899;
  localparam logic [127:0] K128 =
    128'h00112233445566778899aabbccddeeff;
  localparam logic [63:0]  PT0  = 64'h0123456789abcdef;
  localparam logic [63:0]  CT80 = 64'h8d2bff9935f84056;

  logic         clk;
  logic         reset;
  logic         iv   [4];
  logic         ir   [4];
  logic         ov   [4];
  logic         ordy [4];
  logic         bsy  [4];
  logic [63:0]  pt   [4];
  logic [63:0]  ct   [4];
  logic [127:0] kin  [4];

  logic [63:0] expq [4][$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    piccolo_iter_core #(
      .KEY_BITS(KBA[g]),
      .UNROLL  (UNA[g])
    ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .plaintext (pt[g]),
      .key       (kin[g][KBA[g]-1:0]),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .ciphertext(ct[g]),
      .busy      (bsy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s", nm);
  endtask

  // ---------------- golden model ----------------
  function automatic logic [3:0] gmul(input logic [3:0] a,
                                      input int b);
    logic [3:0] p;
    logic [3:0] s;
    p = 4'h0;
    s = a;
    for (int i = 0; i < 2; i++) begin
      if (b[i]) p = p ^ s;
      s = {s[2:0], 1'b0} ^ (s[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

  function automatic logic [15:0] fmod(input logic [15:0] x);
    logic [3:0] n [4];
    logic [3:0] y;
    logic [15:0] o;
    for (int i = 0; i < 4; i++)
      n[i] = SB[4'(x >> (12 - 4 * i))];
    o = 16'h0;
    for (int rr = 0; rr < 4; rr++) begin
      y = 4'h0;
      for (int c = 0; c < 4; c++)
        y = y ^ gmul(n[c], MM[4 * rr + c]);
      o = {o[11:0], SB[y]};
    end
    return o;
  endfunction

  function automatic logic [63:0] rpmod(input logic [63:0] s);
    logic [63:0] o;
    o = 64'h0;
    for (int i = 0; i < 8; i++)
      o = {o[55:0], 8'(s >> (56 - 8 * RPM[i]))};
    return o;
  endfunction

  function automatic logic [31:0] conf(input int i,
                                       input int kb);
    logic [4:0] c;
    c = 5'(i + 1);
    return {c, 5'b0, c, 2'b0, c, 5'b0, c} ^
           ((kb == 80) ? 32'h0f1e2d3c : 32'h6547a98b);
  endfunction

  function automatic logic [63:0] model(input logic [127:0] k,
                                        input int kb,
                                        input logic [63:0] p);
    logic [15:0]  w   [8];
    logic [15:0]  kk  [8];
    logic [15:0]  tp  [8];
    logic [15:0]  rk  [62];
    logic [15:0]  x   [4];
    logic [15:0]  wa;
    logic [127:0] t;
    logic [31:0]  cc;
    logic [63:0]  s;
    int nr;
    nr = (kb == 80) ? 25 : 31;
    for (int j = 0; j < 8; j++) w[j] = 16'h0;
    t = k;
    for (int j = kb / 16 - 1; j >= 0; j--) begin
      w[j] = t[15:0];
      t = t >> 16;
    end
    if (kb == 80) begin
      for (int i = 0; i < nr; i++) begin
        cc = conf(i, 80);
        case (i % 5)
          0, 2: begin
            rk[2*i] = w[2]; rk[2*i+1] = w[3];
          end
          1, 4: begin
            rk[2*i] = w[0]; rk[2*i+1] = w[1];
          end
          default: begin
            rk[2*i] = w[4]; rk[2*i+1] = w[4];
          end
        endcase
        rk[2*i]   = rk[2*i] ^ cc[31:16];
        rk[2*i+1] = rk[2*i+1] ^ cc[15:0];
      end
    end else begin
      kk = w;
      for (int n = 0; n < 2 * nr; n++) begin
        if ((n + 2) % 8 == 0) begin
          tp = kk;
          kk[0] = tp[2]; kk[1] = tp[1];
          kk[2] = tp[6]; kk[3] = tp[7];
          kk[4] = tp[0]; kk[5] = tp[3];
          kk[6] = tp[4]; kk[7] = tp[5];
        end
        cc = conf(n / 2, 128);
        rk[n] = kk[(n + 2) % 8] ^
                ((n % 2 == 0) ? cc[31:16] : cc[15:0]);
      end
    end
    wa = (kb == 80) ? w[3] : w[7];
    x[0] = p[63:48] ^ {w[0][15:8], w[1][7:0]};
    x[1] = p[47:32];
    x[2] = p[31:16] ^ {w[1][15:8], w[0][7:0]};
    x[3] = p[15:0];
    for (int i = 0; i < nr; i++) begin
      x[1] = x[1] ^ fmod(x[0]) ^ rk[2*i];
      x[3] = x[3] ^ fmod(x[2]) ^ rk[2*i+1];
      if (i != nr - 1) begin
        s = rpmod({x[0], x[1], x[2], x[3]});
        x[0] = s[63:48]; x[1] = s[47:32];
        x[2] = s[31:16]; x[3] = s[15:0];
      end
    end
    x[0] = x[0] ^ {w[4][15:8], wa[7:0]};
    x[2] = x[2] ^ {wa[15:8], w[4][7:0]};
    return {x[0], x[1], x[2], x[3]};
  endfunction

  // ---------------- monitor ----------------
  initial begin
    int acc [4];
    bit pov [4];
    for (int g = 0; g < 4; g++) begin
      acc[g] = 0;
      pov[g] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < 4; g++) begin
        if (reset) begin
          pov[g] = 1'b0;
        end else begin
          if (iv[g] && ir[g]) acc[g] = cyc + 1;
          if (ov[g] && !pov[g])
            chk($sformatf("lat%0d", g),
                64'(cyc - acc[g]), 64'(LATA[g]));
          if (ov[g] && ordy[g]) begin
            if (expq[g].size() == 0)
              fail($sformatf("unexpected_out%0d", g));
            else
              chk($sformatf("ct%0d", g), ct[g],
                  expq[g].pop_front());
          end
          pov[g] = ov[g];
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int g,
                      input logic [127:0] k,
                      input logic [63:0] p,
                      input logic [63:0] e);
    bit ok;
    int n;
    kin[g] = k;
    pt[g]  = p;
    iv[g]  = 1'b1;
    expq[g].push_back(e);
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 400) begin
      @(negedge clk);
      ok = ir[g];
      tick();
      n++;
    end
    iv[g]  = 1'b0;
    kin[g] = ~k;
    pt[g]  = ~p;
    if (!ok) fail($sformatf("accept_timeout%0d", g));
  endtask

  task automatic drain(input int g);
    int n;
    n = 0;
    while (expq[g].size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    if (expq[g].size() != 0)
      fail($sformatf("drain_timeout%0d", g));
  endtask

  function automatic logic [127:0] kfit(input int g,
                                        input logic [127:0] k);
    return (KBA[g] == 80) ? {48'h0, k[79:0]} : k;
  endfunction

  task automatic worker(input int g, input int nb);
    bit stop;
    stop = 1'b0;
    fork
      begin
        for (int b = 0; b < nb; b++) begin
          logic [127:0] k;
          logic [63:0]  p;
          k = kfit(g, {$urandom, $urandom, $urandom, $urandom});
          p = {$urandom, $urandom};
          repeat ($urandom_range(0, 3)) tick();
          send(g, k, p, model(k, KBA[g], p));
        end
        drain(g);
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          ordy[g] = ($urandom_range(0, 3) != 0);
          tick();
        end
        ordy[g] = 1'b1;
      end
    join
  endtask

  logic [127:0] kt80  [4];
  logic [127:0] kt128 [4];
  logic [63:0]  ptt   [4];

  initial begin
    int n;
    logic [63:0] held;
    kt80[0]  = K80;  kt128[0] = K128; ptt[0] = PT0;
    kt80[1]  = '0;   kt128[1] = '0;   ptt[1] = '0;
    kt80[2]  = {48'h0, {80{1'b1}}};
    kt128[2] = '1;   ptt[2] = '1;
    kt80[3]  = 128'h0123456789abcdef0123;
    kt128[3] = 128'hfedcba98765432100123456789abcdef;
    ptt[3]   = 64'h8000000000000001;

    reset = 1'b1;
    for (int g = 0; g < 4; g++) begin
      iv[g] = 1'b0; ordy[g] = 1'b0;
      pt[g] = '0;   kin[g]  = '0;
    end
    tick();
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("rst_in_ready%0d", g), 64'(ir[g]), 0);
      chk($sformatf("rst_out_valid%0d", g), 64'(ov[g]), 0);
      chk($sformatf("rst_busy%0d", g), 64'(bsy[g]), 0);
      chk($sformatf("rst_ct%0d", g), ct[g], 0);
    end
    reset = 1'b0;
    tick();
    for (int g = 0; g < 4; g++)
      chk($sformatf("idle_in_ready%0d", g), 64'(ir[g]), 1);
    chk("model80_vector", model(K80, 80, PT0), CT80);

    // directed vectors on all configurations
    for (int g = 0; g < 4; g++) ordy[g] = 1'b1;
    for (int v = 0; v < 4; v++) begin
      fork
        send(0, kt80[v], ptt[v],
             (v == 0) ? CT80 : model(kt80[v], 80, ptt[v]));
        send(1, kt128[v], ptt[v], model(kt128[v], 128, ptt[v]));
        send(2, kt128[v], ptt[v], model(kt128[v], 128, ptt[v]));
        send(3, kt128[v], ptt[v], model(kt128[v], 128, ptt[v]));
      join
      for (int g = 0; g < 4; g++) drain(g);
    end

    // back-pressure in DONE
    repeat (3) tick();
    ordy[1] = 1'b0;
    send(1, K128, PT0, model(K128, 128, PT0));
    n = 0;
    while (!ov[1] && n < 50) begin
      tick();
      n++;
    end
    if (!ov[1]) fail("bp_out_valid_timeout");
    held = ct[1];
    n = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (ov[1] && ct[1] == held && !ir[1]) n++;
    end
    chk("bp_stable_cycles", 64'(n), 20);
    chk("bp_held_ct", held, model(K128, 128, PT0));
    ordy[1] = 1'b1;
    tick();
    chk("bp_release_out_valid", 64'(ov[1]), 0);
    chk("bp_release_in_ready_low", 64'(ir[1]), 0);
    tick();
    chk("bp_release_in_ready_high", 64'(ir[1]), 1);
    drain(1);

    // reset in the middle of RUN
    send(1, kt128[3], ptt[3], model(kt128[3], 128, ptt[3]));
    tick();
    tick();
    chk("run_busy", 64'(bsy[1]), 1);
    reset = 1'b1;
    tick();
    expq[1].delete();
    reset = 1'b0;
    chk("rst_run_out_valid", 64'(ov[1]), 0);
    chk("rst_run_busy", 64'(bsy[1]), 0);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (ov[1]) n++;
    end
    chk("rst_run_no_stale_out", 64'(n), 0);
    send(1, kt128[2], PT0, model(kt128[2], 128, PT0));
    drain(1);

    // random regression, 1000 blocks total
    fork
      worker(0, 250);
      worker(1, 250);
      worker(2, 250);
      worker(3, 250);
    join
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
